// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared constants and types for the vector display DAC path
// Purpose: coordinate width, DAC frame constants and the DAC driver state type.
// Ports: none (package).
package vector_pkg;

   localparam int DAC_WIDTH = 8;
   localparam int DAC_BITS  = 12;

   // Command nibble tail: BUF=1, GA_n=1 (1x gain), SHDN_n=1 (output active)
   localparam logic [2:0] DAC_CFG_BITS = 3'b111;

   localparam logic DAC_CH_A = 1'b0;
   localparam logic DAC_CH_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP,
      LDAC,
      DONE
   } dac_state_t;

   // Upper four bits of a DAC frame for the given channel
   function automatic logic [3:0] dac_cmd(input logic ch);
      return {ch, DAC_CFG_BITS};
   endfunction

endpackage

// File: rtl/dac_spi_driver_spi_tx_shifter.sv
// rtl/dac_spi_driver_spi_tx_shifter.sv - parallel-load MSB-first SPI transmit shift register
// Purpose: holds one SPI frame and presents its current bit on msb.
// Ports: clk, rst (sync, active-high), load/data (parallel load),
//        shift (advance one bit), msb (bit currently on the wire).
module spi_tx_shifter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= data;
      end else if (shift) begin
         sr <= {sr[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = sr[WIDTH-1];

endmodule

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - writes X/Y coordinate pairs to a dual-channel 12-bit SPI DAC
// Purpose: accepts an (x_ch, y_ch) pair by valid/ready, sends channel A (X) then
//          channel B (Y) as 16-bit SPI mode-0 frames, then pulses LDAC so both
//          DAC outputs update together.
// Ports: clk, rst (sync, active-high); x_ch/y_ch/in_valid/in_ready (pair input);
//        dac_cs_n/dac_sck/dac_sdi/dac_ldac_n (DAC pins); done (pair latched pulse).
module dac_spi_driver #(
   parameter int OUT_WIDTH = vector_pkg::DAC_WIDTH,
   parameter int DAC_BITS  = vector_pkg::DAC_BITS,
   parameter int CLK_DIV   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OUT_WIDTH-1:0] x_ch,
   input  logic [OUT_WIDTH-1:0] y_ch,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 dac_cs_n,
   output logic                 dac_sck,
   output logic                 dac_sdi,
   output logic                 dac_ldac_n,
   output logic                 done
);

   import vector_pkg::*;

   localparam int FRAME_BITS = 4 + DAC_BITS;
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_FIRST  = BW'(FRAME_BITS - 1);

   if (OUT_WIDTH > DAC_BITS) begin : g_width_check
      $error("dac_spi_driver: OUT_WIDTH must not exceed DAC_BITS");
   end
   if (CLK_DIV < 1) begin : g_div_check
      $error("dac_spi_driver: CLK_DIV must be at least 1");
   end

   dac_state_t     state, state_d;
   logic [PW-1:0]  phase, phase_d;
   logic [BW-1:0]  bit_cnt, bit_cnt_d;
   logic           sck_high, sck_high_d;   // which half of the current bit
   logic           ch, ch_d;
   logic [OUT_WIDTH-1:0] y_q;

   logic           accept;
   logic           tick;
   logic           load;
   logic           shift;
   logic [OUT_WIDTH-1:0]  coord_sel;
   logic [DAC_BITS-1:0]   coord_just;
   logic [FRAME_BITS-1:0] frame;

   logic ready_d, cs_n_d, sck_d, ldac_n_d, done_d;

   // in_ready is only high in IDLE and DONE, so this is the accept condition
   assign accept = in_valid && in_ready;
   assign tick   = (phase == PHASE_LAST);

   // Frame A is loaded straight from x_ch on accept; frame B from the held Y at
   // the end of GAP, so the inputs are free to change after acceptance.
   assign coord_sel  = (state == GAP) ? y_q : x_ch;
   assign coord_just = DAC_BITS'(coord_sel) << (DAC_BITS - OUT_WIDTH);
   assign frame      = {dac_cmd((state == GAP) ? DAC_CH_B : DAC_CH_A), coord_just};

   always_comb begin
      state_d    = state;
      phase_d    = tick ? '0 : phase + PW'(1);
      bit_cnt_d  = bit_cnt;
      sck_high_d = sck_high;
      ch_d       = ch;
      load       = 1'b0;
      shift      = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            phase_d = '0;
            if (accept) begin
               state_d    = SHIFT;
               bit_cnt_d  = BIT_FIRST;
               sck_high_d = 1'b0;
               ch_d       = DAC_CH_A;
               load       = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sck_high) begin
                  sck_high_d = 1'b1;
               end else if (bit_cnt == '0) begin
                  state_d    = HOLD;
                  sck_high_d = 1'b0;
               end else begin
                  // next bit appears at the start of its low phase
                  sck_high_d = 1'b0;
                  bit_cnt_d  = bit_cnt - BW'(1);
                  shift      = 1'b1;
               end
            end
         end
         HOLD: begin
            if (tick) state_d = GAP;
         end
         GAP: begin
            if (tick) begin
               if (ch == DAC_CH_A) begin
                  state_d    = SHIFT;
                  ch_d       = DAC_CH_B;
                  bit_cnt_d  = BIT_FIRST;
                  sck_high_d = 1'b0;
                  load       = 1'b1;
               end else begin
                  state_d = LDAC;
               end
            end
         end
         LDAC: begin
            if (tick) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      // Pin values are decoded from the next state and registered below
      ready_d  = (state_d == IDLE) || (state_d == DONE);
      cs_n_d   = !((state_d == SHIFT) || (state_d == HOLD));
      sck_d    = (state_d == SHIFT) && sck_high_d;
      ldac_n_d = (state_d != LDAC);
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         bit_cnt    <= BIT_FIRST;
         sck_high   <= 1'b0;
         ch         <= DAC_CH_A;
         y_q        <= '0;
         in_ready   <= 1'b1;
         dac_cs_n   <= 1'b1;
         dac_sck    <= 1'b0;
         dac_ldac_n <= 1'b1;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         phase      <= phase_d;
         bit_cnt    <= bit_cnt_d;
         sck_high   <= sck_high_d;
         ch         <= ch_d;
         if (accept) y_q <= y_ch;
         in_ready   <= ready_d;
         dac_cs_n   <= cs_n_d;
         dac_sck    <= sck_d;
         dac_ldac_n <= ldac_n_d;
         done       <= done_d;
      end
   end

   spi_tx_shifter #(
      .WIDTH (FRAME_BITS)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .data  (frame),
      .msb   (dac_sdi)
   );

endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
Downstream stage of top_vector_display. Takes the x_ch/y_ch beam coordinates and writes them to an external dual-channel 12-bit SPI DAC (MCP4922-class): channel A = X, channel B = Y. The DAC's LDAC input is then pulsed so both outputs update together, which prevents beam skew between axes. A valid/ready handshake lets the display core hold each point until the driver accepts it.

Parameters:
OUT_WIDTH, DAC_WIDTH (vector_pkg, 8), width of incoming coordinate words
DAC_BITS, 12, DAC resolution; OUT_WIDTH <= DAC_BITS (elaboration assertion)
CLK_DIV, 4, SCK half-period in clk cycles; legal range >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
x_ch  in  OUT_WIDTH  X coordinate (channel A)
y_ch  in  OUT_WIDTH  Y coordinate (channel B)
in_valid  in  1  coordinate pair valid
in_ready  out  1  driver idle, can accept a pair
dac_cs_n  out  1  SPI chip select, active-low
dac_sck  out  1  SPI clock, mode 0 (idles low)
dac_sdi  out  1  SPI data, MSB first
dac_ldac_n  out  1  DAC latch strobe, active-low
done  out  1  one-cycle pulse when a pair has been latched

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: in_ready=1, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ldac_n=1, done=0, FSM=IDLE.
- All outputs are registered. A reset asserted mid-transfer aborts the transfer at the next clk edge with the reset values above. No partial LDAC pulse is produced.
- Accept: x_ch and y_ch are captured on the edge where in_valid && in_ready. in_ready drops in the following cycle. in_valid without in_ready is ignored. Inputs may change freely after acceptance.
- SPI frame (16 bits): [15] channel (0=A/X, 1=B/Y), [14] BUF=1, [13] GA_n=1, [12] SHDN_n=1, [11:0] data.
- Data is left-justified: {coord, (DAC_BITS-OUT_WIDTH) zeros}.
- FSM states and transitions:
  - IDLE: in_ready=1; on accept go to SHIFT with ch=A.
  - SHIFT: dac_cs_n=0. For each of 16 bits, dac_sck is low for CLK_DIV cycles, then high for CLK_DIV cycles. dac_sdi changes only while SCK is low, at the start of each bit's low phase. After bit 0's high phase, go to HOLD.
  - HOLD: dac_cs_n=0, sck=0 for CLK_DIV cycles, then go to GAP.
  - GAP: dac_cs_n=1 for CLK_DIV cycles. If ch=A, set ch=B and go to SHIFT; otherwise go to LDAC.
  - LDAC: dac_ldac_n=0 for CLK_DIV cycles, then go to DONE.
  - DONE: done=1 and in_ready=1 for exactly one cycle. Then go to IDLE, or go directly to SHIFT if in_valid is high in that cycle (back-to-back accept).
- Timing: if acceptance occurs at edge N, dac_cs_n is low from cycle N+1 with the frame-A MSB already on dac_sdi. done is high in cycle N+1+69*CLK_DIV, which is 277 for CLK_DIV=4.
- Per channel: 34*CLK_DIV cycles (32 SCK phases + hold + gap).
- Counters: phase counter spans 0..CLK_DIV-1; bit counter spans 15..0. Both wrap and reload on every state entry.
- dac_ldac_n is never low while dac_cs_n is low.

Decomposition:
- vector_pkg gains:
  - DAC_BITS
  - DAC_CFG_BITS = 3'b111 (BUF, GA_n, SHDN_n)
  - DAC_CH_A = 1'b0, DAC_CH_B = 1'b1
  - typedef enum dac_state_t {IDLE, SHIFT, HOLD, GAP, LDAC, DONE}
- One sub-module, spi_tx_shifter: a 16-bit parallel-load MSB-first shift register with a shift-enable input, driven by the FSM's phase-counter tick.
- The FSM and clock divider stay in dac_spi_driver.

Test Plan:
- Basic pair: x=8'hA5, y=8'h3C, CLK_DIV=4.
  - Sampling dac_sdi on SCK rising edges gives 16'h7A50, then 16'hF3C0.
  - dac_cs_n shows two low windows.
  - dac_ldac_n goes low once, after the second CS rises.
  - done occurs exactly 277 cycles after acceptance.
- Handshake:
  - Hold in_valid=1 with changing data during the transfer: in_ready stays 0 and only the accepted pair is shifted.
  - Assert in_valid during DONE: the next frame's dac_cs_n falls in the cycle after done, with no IDLE cycle.
- Boundaries:
  - x=8'h00 and y=8'hFF give frames 16'h7000 and 16'hFFF0.
  - CLK_DIV=1 gives done at acceptance+70 cycles, with SCK toggling every cycle.
- Reset mid-transfer: assert rst at bit 7 of channel B.
  - The next cycle shows cs_n=1, sck=0, ldac_n=1, in_ready=1, with no done pulse.
  - A following pair transmits correctly.
- Integration: connect to top_vector_display and uwu_rom.
  - Decode SPI with a bench model of the DAC.
  - Latched (X,Y) pairs must equal the ROM's data bits [9:2] and [17:10], in address order.
  - frame_drawn must occur 4 times with no dropped points.
